// File: rtl/ps2_event_fifo_if.sv
// rtl/ps2_event_fifo_if.sv - byte-receiver inputs and event-queue outputs of ps2_event_fifo
interface ps2_event_fifo_if #(
    parameter int DEPTH_LOG2 = 3
) ();
    logic [7:0]          code;
    logic                strobe;
    logic                err;
    logic                rd;
    logic                clr;
    logic                ev_valid;
    logic [9:0]          ev_data;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                kbd_overrun;

    modport master (
        output code, strobe, err, rd, clr,
        input  ev_valid, ev_data, count, overflow, kbd_overrun
    );

    modport slave (
        input  code, strobe, err, rd, clr,
        output ev_valid, ev_data, count, overflow, kbd_overrun
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - folds E0/F0 prefixes into 10-bit key events and queues them (FWFT)
// Optional typematic-repeat suppression: define PS2EV_REPEAT_FILTER_EN.
module ps2_event_fifo #(
    parameter int          DEPTH_LOG2     = 3,
    parameter logic [23:0] PREFIX_TIMEOUT = 24'd2500000
) (
    input  logic             clk,
    input  logic             reset,
    ps2_event_fifo_if.slave  bus
);
    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [23:0]         r_tmo;
    logic                w_tmo_hit;
    logic                w_bad;
    logic                w_emit;
    logic                w_ovr_set;
    logic [9:0]          w_ev;
    logic                w_push;

    assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo == PREFIX_TIMEOUT - 24'd1);
    assign w_bad     = bus.strobe && (bus.code == 8'h00 || bus.code == 8'hFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.err) begin
            w_state_nxt = S_IDLE;
        end else if (bus.strobe) begin
            if (w_bad)                  w_state_nxt = S_IDLE;
            else if (bus.code == 8'hE0) w_state_nxt = S_E0;
            else if (bus.code == 8'hF0) w_state_nxt = (r_state == S_E0 || r_state == S_E0F0) ? S_E0F0 : S_F0;
            else                        w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_emit    = !bus.err && bus.strobe && !w_bad && bus.code != 8'hE0 && bus.code != 8'hF0;
        w_ovr_set = !bus.err && w_bad;
        w_ev      = {(r_state == S_E0 || r_state == S_E0F0), (r_state == S_F0 || r_state == S_E0F0), bus.code};
    end

    // Idle-time budget for a half-received prefix sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_tmo <= '0;
        else if (bus.strobe)        r_tmo <= '0;
        else if (r_state != S_IDLE) r_tmo <= w_tmo_hit ? '0 : r_tmo + 24'd1;
    end

`ifdef PS2EV_REPEAT_FILTER_EN
    logic [511:0] r_down;
    logic [8:0]   w_idx;
    assign w_idx  = {w_ev[9], w_ev[7:0]};
    assign w_push = w_emit && !(!w_ev[8] && r_down[w_idx]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_down <= '0;
        else if (w_emit) r_down[w_idx] <= !w_ev[8];
    end
`else
    assign w_push = w_emit;
`endif

    logic [9:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2-1:0] w_rp_nxt;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_rem;
    logic [9:0]            r_head;
    logic                  r_overflow;
    logic                  r_kbd_overrun;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;

    assign w_pop    = bus.rd && (r_count != '0);
    assign w_wr     = w_push && (r_count != FULL || w_pop);
    assign w_drop   = w_push && (r_count == FULL) && !w_pop;
    assign w_rp_nxt = w_pop ? r_rp + DEPTH_LOG2'(1) : r_rp;
    assign w_rem    = w_pop ? r_count - (DEPTH_LOG2 + 1)'(1) : r_count;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= w_ev;
    end

    // r_head pre-loads the next head entry so ev_data is a clean register output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_overflow    <= 1'b0;
            r_kbd_overrun <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + DEPTH_LOG2'(1);
            r_rp    <= w_rp_nxt;
            r_count <= w_wr ? w_rem + (DEPTH_LOG2 + 1)'(1) : w_rem;
            if (w_rem != '0)  r_head <= r_mem[w_rp_nxt];
            else if (w_wr)    r_head <= w_ev;
            r_overflow    <= (r_overflow && !bus.clr) || w_drop;
            r_kbd_overrun <= (r_kbd_overrun && !bus.clr) || w_ovr_set;
        end
    end

    assign bus.ev_valid    = (r_count != '0);
    assign bus.ev_data     = r_head;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.kbd_overrun = r_kbd_overrun;
endmodule

// File: tb/tb_ps2_event_fifo.sv
// tb/tb_ps2_event_fifo.sv - directed stimulus, queue-based event model and literal spot checks
module tb_ps2_event_fifo;
    localparam int DL    = 3;
    localparam int DEPTH = 8;
    localparam int PT    = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_event_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    ps2_event_fifo #(.DEPTH_LOG2(DL), .PREFIX_TIMEOUT(24'(PT))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: prefix flags plus a queue of pending events.
    logic [9:0] m_q[$];
    logic [9:0] m_last = '0;
    logic [9:0] m_ev;
    bit m_ovf, m_kov, m_pend, m_ext, m_rel, m_pop, m_have, m_set_ovf, m_set_kov;
    int m_idle, m_sz;
    bit m_down [512];

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_last = '0; m_ovf = 0; m_kov = 0;
            m_pend = 0; m_ext = 0; m_rel = 0; m_idle = 0;
            foreach (m_down[i]) m_down[i] = 0;
        end else begin
            m_sz = m_q.size();
            m_pop = bus.rd && m_sz > 0;
            m_have = 0; m_set_ovf = 0; m_set_kov = 0;
            if (bus.err) begin
                m_pend = 0; m_ext = 0; m_rel = 0; m_idle = 0;
            end else if (bus.strobe) begin
                m_idle = 0;
                if (bus.code == 8'h00 || bus.code == 8'hFF) begin
                    m_set_kov = 1; m_pend = 0; m_ext = 0; m_rel = 0;
                end else if (bus.code == 8'hE0) begin
                    m_pend = 1; m_ext = 1; m_rel = 0;
                end else if (bus.code == 8'hF0) begin
                    m_pend = 1; m_rel = 1;
                end else begin
                    m_have = 1; m_ev = {m_ext, m_rel, bus.code};
                    m_pend = 0; m_ext = 0; m_rel = 0;
                end
            end else if (m_pend) begin
                m_idle++;
                if (m_idle == PT) begin m_pend = 0; m_ext = 0; m_rel = 0; m_idle = 0; end
            end
`ifdef PS2EV_REPEAT_FILTER_EN
            if (m_have) begin
                if (!m_ev[8]) begin
                    if (m_down[{m_ev[9], m_ev[7:0]}]) m_have = 0;
                    m_down[{m_ev[9], m_ev[7:0]}] = 1;
                end else m_down[{m_ev[9], m_ev[7:0]}] = 0;
            end
`endif
            if (m_pop) void'(m_q.pop_front());
            if (m_have) begin
                if (m_sz == DEPTH && !m_pop) m_set_ovf = 1;
                else m_q.push_back(m_ev);
            end
            if (m_q.size() > 0) m_last = m_q[0];
            m_ovf = (m_ovf && !bus.clr) || m_set_ovf;
            m_kov = (m_kov && !bus.clr) || m_set_kov;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("ev_valid", 32'(bus.ev_valid), 32'(m_q.size() != 0));
            check("ev_data", 32'(bus.ev_data), 32'(m_q.size() != 0 ? m_q[0] : m_last));
            check("count", 32'(bus.count), 32'(m_q.size()));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("kbd_overrun", 32'(bus.kbd_overrun), 32'(m_kov));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.code = b; bus.strobe = 1'b1; tick(); bus.strobe = 1'b0;
    endtask

    task automatic pop();
        bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    endtask

    task automatic look(input string nm, input logic [31:0] act, input logic [31:0] exp);
        check(nm, act, exp);
    endtask

    initial begin
        bus.code = '0; bus.strobe = 0; bus.err = 0; bus.rd = 0; bus.clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        look("rst_ev_valid", 32'(bus.ev_valid), 0);
        look("rst_ev_data", 32'(bus.ev_data), 0);
        look("rst_count", 32'(bus.count), 0);
        look("rst_overflow", 32'(bus.overflow), 0);
        look("rst_kbd_overrun", 32'(bus.kbd_overrun), 0);
        reset = 1'b0;
        tick();

        send(8'h1C);
        @(negedge clk);
        look("make_valid", 32'(bus.ev_valid), 1);
        look("make_data", 32'(bus.ev_data), 32'h01C);
        look("make_count", 32'(bus.count), 1);
        tick();
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        look("break_count", 32'(bus.count), 2);
        tick();
        pop(); pop();

        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk);
        look("ext_make", 32'(bus.ev_data), 32'h275);
        tick(); pop();
        @(negedge clk);
        look("ext_break", 32'(bus.ev_data), 32'h375);
        tick(); pop(); pop();
        @(negedge clk);
        look("drained_valid", 32'(bus.ev_valid), 0);
        look("drained_hold", 32'(bus.ev_data), 32'h375);
        tick();

        send(8'hF0);
        bus.err = 1'b1; tick(); bus.err = 1'b0;
        send(8'h29);
        @(negedge clk);
        look("err_abort", 32'(bus.ev_data), 32'h029);
        tick(); pop();

        send(8'hE0);
        repeat (PT + 1) tick();
        send(8'h6B);
        @(negedge clk);
        look("timeout", 32'(bus.ev_data), 32'h06B);
        tick(); pop();
        send(8'hE0);
        repeat (PT - 2) tick();
        send(8'h6B);
        @(negedge clk);
        look("no_timeout", 32'(bus.ev_data), 32'h26B);
        tick(); pop();

        send(8'hFF);
        @(negedge clk);
        look("overrun_set", 32'(bus.kbd_overrun), 1);
        look("overrun_count", 32'(bus.count), 0);
        tick(); pulse_clr();
        @(negedge clk);
        look("overrun_clr", 32'(bus.kbd_overrun), 0);
        tick();
        bus.code = 8'h00; bus.strobe = 1'b1; bus.clr = 1'b1; tick();
        bus.strobe = 1'b0; bus.clr = 1'b0;
        @(negedge clk);
        look("set_wins", 32'(bus.kbd_overrun), 1);
        tick(); pulse_clr();

        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        @(negedge clk);
        look("full_count", 32'(bus.count), 8);
        look("full_overflow", 32'(bus.overflow), 1);
        look("full_head", 32'(bus.ev_data), 32'h010);
        tick(); pulse_clr();
        bus.code = 8'h20; bus.strobe = 1'b1; bus.rd = 1'b1; tick();
        bus.strobe = 1'b0; bus.rd = 1'b0;
        @(negedge clk);
        look("rw_full_count", 32'(bus.count), 8);
        look("rw_full_ovf", 32'(bus.overflow), 0);
        tick();
        repeat (7) pop();
        @(negedge clk);
        look("tail_event", 32'(bus.ev_data), 32'h020);
        tick(); pop();
        bus.code = 8'h21; bus.strobe = 1'b1; bus.rd = 1'b1; tick();
        bus.strobe = 1'b0; bus.rd = 1'b0;
        @(negedge clk);
        look("rw_empty_count", 32'(bus.count), 1);
        look("rw_empty_data", 32'(bus.ev_data), 32'h021);
        tick(); pop();

        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        @(negedge clk);
`ifdef PS2EV_REPEAT_FILTER_EN
        look("repeat_count", 32'(bus.count), 3);
`else
        look("repeat_count", 32'(bus.count), 5);
`endif
        tick();
        repeat (5) pop();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ps2_event_fifo.md
Name: ps2_event_fifo

Overview:
- Sits directly downstream of the PS/2 byte receiver, consuming its `code`/`strobe`/`err` outputs.
- Folds E0 (extended) and F0 (break) prefix bytes into single 10-bit key events.
- Buffers events in a small first-word-fall-through FIFO for CPU/TMS9900-side polling, so no key transitions are lost while software is busy.
- Also flags keyboard overrun and FIFO overflow conditions.

Parameters:
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 events (default 8).
- PREFIX_TIMEOUT, 24'd2500000: clk cycles without a strobe after which a pending prefix is abandoned (about 100 ms at 25 MHz).

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- code  in  8  received scan code byte; valid only when strobe=1.
- strobe  in  1  one-cycle pulse, new byte on code.
- err  in  1  one-cycle pulse, receiver parity/stop error.
- rd  in  1  pop request; honoured only when ev_valid=1.
- clr  in  1  clears the overflow and kbd_overrun sticky flags.
- ev_valid  out  1  FIFO non-empty.
- ev_data  out  10  head event: [9]=extended, [8]=release, [7:0]=code.
- count  out  DEPTH_LOG2+1  number of events held, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- kbd_overrun  out  1  sticky: keyboard sent 0x00 or 0xFF.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all outputs to 0; ev_data=0;
  - FIFO pointers to 0, prefix state to IDLE, timeout counter to 0.
- Prefix FSM. States: IDLE, E0, F0, E0F0. It acts only on cycles with strobe=1.
  - IDLE: 0xE0 -> E0; 0xF0 -> F0; any other code -> emit {0,0,code}, stay IDLE.
  - E0: 0xF0 -> E0F0; 0xE0 -> E0; other -> emit {1,0,code}, go to IDLE.
  - F0: 0xE0 -> E0 (stale break discarded); 0xF0 -> F0; other -> emit {0,1,code}, go to IDLE.
  - E0F0: 0xE0 -> E0; 0xF0 -> E0F0; other -> emit {1,1,code}, go to IDLE.
  - Codes 0x00 and 0xFF, in any state: set kbd_overrun, emit nothing, go to IDLE.
  - err=1: go to IDLE and emit nothing. err has priority over a simultaneous strobe.
- Timeout:
  - The counter clears on every strobe and counts only while state != IDLE.
  - When it reaches PREFIX_TIMEOUT-1, the FSM goes to IDLE and the counter clears. No event is emitted.
- Emit/write:
  - An emitted event is written into the FIFO in the same clk as the final strobe.
  - ev_valid/ev_data/count reflect it on the next clk (1-cycle latency from strobe to ev_valid).
- FIFO:
  - First-word fall-through; ev_data always shows the head entry while ev_valid=1.
  - ev_data holds its last value when empty.
  - rd with ev_valid=0 is ignored.
- Full:
  - A write while full with no rd in the same cycle drops the event and sets overflow.
  - rd and write in the same cycle while full: pop and push both succeed, count stays at full, overflow is not set.
- Empty: rd and write in the same cycle while empty only writes; count becomes 1.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is derived from write minus read, tracked at width DEPTH_LOG2+1.
- Sticky flags:
  - clr clears overflow and kbd_overrun.
  - If clr and a new setting condition occur in the same cycle, the flag ends up set (set wins).

Optional Feature:
- Macro: PS2EV_REPEAT_FILTER_EN.
- Defined:
  - The block keeps a 256-entry x 2 (plain/extended) key-down bitmap.
  - A make event for a key already marked down is discarded (typematic repeat suppression).
  - A make event sets the key's bit; a break event clears it.
  - err, timeout and kbd_overrun do not touch the bitmap. reset clears it.
- Undefined: every make event is enqueued, including typematic repeats. No bitmap logic is present.

Test Plan:
- Reset, then bytes 0x1C → ev_valid=1 one clk after the strobe, ev_data=0x01C, count=1. Then bytes F0, 1C → second event 0x11C, count=2.
- Bytes E0 75, then E0 F0 75 → events 0x275 and 0x375 in order; rd twice → ev_valid=0, count=0.
- Bytes F0 then err pulse, then 0x29 → single event 0x029; no release bit set.
- Byte E0, then PREFIX_TIMEOUT+1 clk idle, then 0x6B → event 0x06B (extended bit cleared). Byte 0xFF → kbd_overrun=1, nothing enqueued; clr → kbd_overrun=0.
- Enqueue 9 makes into a depth-8 FIFO → count=8, overflow=1, ninth event lost. Then rd and new strobe in the same clk while full → count stays 8, new event appears at the tail after 7 pops.
- With PS2EV_REPEAT_FILTER_EN: bytes 1C, 1C, 1C, F0 1C, 1C → events 0x01C, 0x11C, 0x01C only. Without the macro: 5 events.
